gb_trace_buffer: RTL and testbench

GB_TRACE_BUFFER -- requirements
Module: gb_trace_buffer

---
 rtl/gb_trace_buffer.sv | 115 +++++++++++
 tb/tb_gb_trace_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gb_trace_buffer.sv
// Trace buffer: captures a sample stream into a circular RAM around a trigger
// event (immediate, pattern match or external) and offers registered readout.
module gb_trace_buffer #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] match_val,
  input  logic [DATA_W-1:0] match_mask,
  input  logic              ext_trig,
  input  logic [ADDR_W-1:0] post_count,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic [1:0]        state,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic [ADDR_W-1:0] trig_index,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_TRIG  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t            st_q, st_d;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] match_val_q, match_mask_q;
  logic [ADDR_W-1:0] post_q;
  logic [ADDR_W-1:0] wr_ptr, trig_ptr, remaining, oldest, rd_idx;
  logic [ADDR_W:0]   wr_count_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en, hit, trig_fire;

  // arm wins over any write on the same cycle, so that sample is dropped
  always_comb begin
    wr_en = (st_q == S_ARMED || st_q == S_TRIG) && sample_valid && !arm;
    unique case (mode_q)
      2'b01:   hit = ((sample_in ^ match_val_q) & match_mask_q) == '0;
      2'b10:   hit = ext_trig;
      default: hit = 1'b1;
    endcase
    trig_fire = wr_en && (st_q == S_ARMED) && hit;
    oldest    = (wr_count_q == FULL_CNT) ? wr_ptr : '0;
    rd_idx    = oldest + rd_addr;
  end

  always_comb begin
    st_d = st_q;
    if (arm)
      st_d = S_ARMED;
    else if (trig_fire)
      st_d = (post_q == '0) ? S_DONE : S_TRIG;
    else if (wr_en && st_q == S_TRIG && remaining == ADDR_W'(1))
      st_d = S_DONE;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q         <= S_IDLE;
      mode_q       <= '0;
      match_val_q  <= '0;
      match_mask_q <= '0;
      post_q       <= '0;
      wr_ptr       <= '0;
      wr_count_q   <= '0;
      remaining    <= '0;
      trig_ptr     <= '0;
      rd_data      <= '0;
    end else begin
      st_q    <= st_d;
      rd_data <= mem[rd_idx];
      if (arm) begin
        mode_q       <= mode;
        match_val_q  <= match_val;
        match_mask_q <= match_mask;
        post_q       <= post_count;
        wr_ptr       <= '0;
        wr_count_q   <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (wr_count_q != FULL_CNT)
          wr_count_q <= wr_count_q + (ADDR_W+1)'(1);
        if (trig_fire) begin
          trig_ptr  <= wr_ptr;
          remaining <= post_q;
        end else if (st_q == S_TRIG) begin
          remaining <= remaining - ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en)
      mem[wr_ptr] <= sample_in;
  end

  assign state      = st_q;
  assign triggered  = (st_q == S_TRIG) || (st_q == S_DONE);
  assign done       = (st_q == S_DONE);
  assign wr_count   = wr_count_q;
  assign trig_index = trig_ptr - oldest;

endmodule

// File: tb/tb_gb_trace_buffer.sv
// Bench for gb_trace_buffer (DATA_W=8, DEPTH=8): vector table, directed
// corner sequences and randomized traffic against a queue-based reference.
module tb_gb_trace_buffer;

  logic       Clk = 1'b0;
  logic       reset_n;
  logic       arm;
  logic [1:0] mode;
  logic [7:0] match_val, match_mask;
  logic       ext_trig;
  logic [2:0] post_count;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic [1:0] state;
  logic       triggered, done;
  logic [3:0] wr_count;
  logic [2:0] trig_index;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;

  gb_trace_buffer #(.DATA_W(8), .DEPTH(8)) dut (
    .Clk(Clk), .reset_n(reset_n), .arm(arm), .mode(mode),
    .match_val(match_val), .match_mask(match_mask), .ext_trig(ext_trig),
    .post_count(post_count), .sample_in(sample_in), .sample_valid(sample_valid),
    .state(state), .triggered(triggered), .done(done), .wr_count(wr_count),
    .trig_index(trig_index), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: stored samples kept oldest-first in a queue
  bit [7:0] q[$];
  int       ph;          // 0 idle, 1 armed, 2 triggered, 3 done
  int       total;       // samples stored since arm
  int       trig_abs;    // sequence number of the trigger sample
  int       rem;
  bit [1:0] c_mode;
  bit [7:0] c_val, c_mask;
  int       c_post;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    ph = 0; total = 0; trig_abs = 0; rem = 0;
    c_mode = 0; c_val = 0; c_mask = 0; c_post = 0;
  endfunction

  function automatic void model_edge();
    bit fire;
    if (arm) begin
      q.delete();
      ph = 1; total = 0;
      c_mode = mode; c_val = match_val; c_mask = match_mask; c_post = post_count;
    end else if ((ph == 1 || ph == 2) && sample_valid) begin
      q.push_back(sample_in);
      if (q.size() > 8) void'(q.pop_front());
      total++;
      if (ph == 1) begin
        case (c_mode)
          2'd1:    fire = ((sample_in ^ c_val) & c_mask) == 8'h00;
          2'd2:    fire = ext_trig;
          default: fire = 1'b1;
        endcase
        if (fire) begin
          trig_abs = total - 1;
          if (c_post == 0) ph = 3;
          else begin ph = 2; rem = c_post; end
        end
      end else begin
        rem--;
        if (rem == 0) ph = 3;
      end
    end
  endfunction

  task automatic step();
    bit       rd_ok;
    bit [7:0] exp_rd;
    rd_ok  = (int'(rd_addr) < q.size());
    exp_rd = rd_ok ? q[rd_addr] : 8'h00;
    @(posedge Clk);
    model_edge();
    #1;
    chk("state", state, ph);
    chk("triggered", triggered, int'(ph >= 2));
    chk("done", done, int'(ph == 3));
    chk("wr_count", wr_count, q.size());
    if (ph >= 2)
      chk("trig_index", trig_index, (trig_abs - (total - q.size())) & 7);
    if (rd_ok) chk("rd_data", rd_data, exp_rd);
  endtask

  task automatic idle_inputs();
    arm = 0; sample_valid = 0; ext_trig = 0; sample_in = 0;
  endtask

  typedef struct {
    bit       arm;
    bit [1:0] mode;
    bit [2:0] post;
    bit       valid;
    bit       ext;
    bit [7:0] smp;
    int       exp_state;
    int       exp_wr;
    int       exp_tidx;   // -1: not checked
  } vec_t;

  vec_t vt[$];

  initial begin
    reset_n = 0; mode = 0; match_val = 0; match_mask = 0; post_count = 0; rd_addr = 0;
    idle_inputs();
    model_reset();
    #12;
    chk("rst_state", state, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done", done, 0);
    #10 reset_n = 1;

    // masked match, external trigger, re-arm dropping sample, mode 11
    vt.push_back('{1, 2'd1, 3'd1, 0, 0, 8'h00, 1, 0, -1});
    vt.push_back('{0, 2'd1, 3'd1, 1, 0, 8'h21, 1, 1, -1});
    vt.push_back('{0, 2'd1, 3'd1, 1, 0, 8'h3E, 2, 2, 1});
    vt.push_back('{0, 2'd1, 3'd1, 1, 0, 8'h40, 3, 3, 1});
    vt.push_back('{1, 2'd2, 3'd0, 1, 0, 8'h55, 1, 0, -1});
    vt.push_back('{0, 2'd2, 3'd0, 0, 1, 8'h66, 1, 0, -1});
    vt.push_back('{0, 2'd2, 3'd0, 1, 0, 8'h01, 1, 1, -1});
    vt.push_back('{0, 2'd2, 3'd0, 1, 1, 8'h02, 3, 2, 1});
    vt.push_back('{0, 2'd2, 3'd0, 1, 1, 8'h03, 3, 2, 1});
    vt.push_back('{1, 2'd3, 3'd0, 0, 0, 8'h00, 1, 0, -1});
    vt.push_back('{0, 2'd3, 3'd0, 1, 0, 8'h77, 3, 1, 0});
    match_val = 8'h30; match_mask = 8'hF0;
    for (int i = 0; i < vt.size(); i++) begin
      arm = vt[i].arm; mode = vt[i].mode; post_count = vt[i].post;
      sample_valid = vt[i].valid; ext_trig = vt[i].ext; sample_in = vt[i].smp;
      step();
      chk($sformatf("vec%0d_state", i), state, vt[i].exp_state);
      chk($sformatf("vec%0d_wr", i), wr_count, vt[i].exp_wr);
      if (vt[i].exp_tidx >= 0) chk($sformatf("vec%0d_tidx", i), trig_index, vt[i].exp_tidx);
    end
    idle_inputs();

    // immediate trigger, post_count = 3
    arm = 1; mode = 0; post_count = 3; step(); arm = 0;
    for (int i = 0; i < 16; i++) begin
      sample_valid = 1; sample_in = 8'(8'h10 + i);
      step();
      if (i == 2) chk("imm_trig_before_last", state, 2);
      if (i == 3) chk("imm_done_after_13", state, 3);
    end
    idle_inputs();
    chk("imm_wr_count", wr_count, 4);
    chk("imm_trig_index", trig_index, 0);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 3'(i); step(); step();
      chk($sformatf("imm_rd%0d", i), rd_data, 8'h10 + i);
    end

    // full pattern match with wrap-around
    arm = 1; mode = 1; match_val = 8'hA5; match_mask = 8'hFF; post_count = 2; step(); arm = 0;
    for (int i = 0; i < 15; i++) begin
      sample_valid = 1;
      sample_in = (i < 12) ? 8'(i) : (i == 12) ? 8'hA5 : 8'(i - 1);
      step();
    end
    idle_inputs();
    chk("wrap_wr_count", wr_count, 8);
    chk("wrap_trig_index", trig_index, 5);
    chk("wrap_done", done, 1);
    rd_addr = 0; step(); step(); chk("wrap_oldest", rd_data, 8'h07);
    rd_addr = 7; step(); step(); chk("wrap_rd7", rd_data, 8'h0D);

    // asynchronous reset in TRIGGERED
    arm = 1; mode = 0; post_count = 5; step(); arm = 0;
    for (int i = 0; i < 3; i++) begin sample_valid = 1; sample_in = 8'(i); step(); end
    idle_inputs();
    chk("pre_reset_trig", state, 2);
    reset_n = 0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_wr_count", wr_count, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_rd_data", rd_data, 0);
    model_reset();
    @(posedge Clk); #3 reset_n = 1;
    sample_valid = 1; sample_in = 8'h99; step();
    chk("no_capture_without_arm", wr_count, 0);
    idle_inputs();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      arm          = ($urandom_range(0, 39) == 0) || (i == 0);
      mode         = 2'($urandom_range(0, 3));
      match_val    = 8'($urandom_range(0, 15));
      match_mask   = 8'($urandom_range(0, 15));
      post_count   = 3'($urandom_range(0, 7));
      sample_valid = $urandom_range(0, 9) < 7;
      ext_trig     = $urandom_range(0, 7) == 0;
      sample_in    = 8'($urandom_range(0, 255));
      rd_addr      = 3'($urandom_range(0, 7));
      step();
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
